// File: rtl/reg_read_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_pkg
//  Description : Shared defaults, response-queue state encoding and the
//                response payload type for the register read unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_read_pkg;

    // Default geometry of the register storage
    localparam int c_DATA_W   = 16;
    localparam int c_ADDR_W   = 3;
    localparam int c_NUM_REGS = 8;

    // Response queue occupancy
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_TWO   = 2'd2
    } q_state_t;

    // Response payload at the default data width: {err, data}
    typedef struct packed {
        logic                err;
        logic [c_DATA_W-1:0] data;
    } rsp_t;

endpackage : reg_read_pkg
`default_nettype wire

// File: rtl/reg_read_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_unit_if
//  Description : Bus bundle for the register read unit: enable-style write
//                port, valid/ready read request and valid/ready read response.
//                master  - drives writes, requests, response ready (consumer)
//                slave   - the register read unit
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_read_unit_if
    import reg_read_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [ADDR_W-1:0] rd_req_addr;

    logic              rd_rsp_valid;
    logic              rd_rsp_ready;
    logic [DATA_W-1:0] rd_rsp_data;
    logic              rd_rsp_err;

    modport master (
        output wr_en, wr_addr, wr_data,
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_rsp_data, rd_rsp_err,
        output rd_rsp_ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready,
        output rd_rsp_valid, rd_rsp_data, rd_rsp_err,
        input  rd_rsp_ready
    );

endinterface : reg_read_unit_if
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rd_skid_buf
//  Description : Two-entry in-order response queue. The head entry drives the
//                output; a second entry absorbs one extra response while the
//                consumer stalls. The input ready is a flop, so there is no
//                combinational path from i_pop_ready to o_push_ready.
//  Ports       : clk, rst          clock, async active-high reset
//                i_push_valid      new payload offered
//                o_push_ready      queue can take a payload (registered)
//                i_push_data       payload in
//                o_pop_valid       head entry valid
//                i_pop_ready       consumer takes head entry
//                o_pop_data        head payload
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_skid_buf
    import reg_read_pkg::*;
#(
    parameter int PAYLOAD_W = c_DATA_W + 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_push_valid,
    output logic                      o_push_ready,
    input  wire logic [PAYLOAD_W-1:0] i_push_data,
    output logic                      o_pop_valid,
    input  wire logic                 i_pop_ready,
    output logic [PAYLOAD_W-1:0]      o_pop_data
);

    q_state_t              r_state_q;
    q_state_t              w_state_d;
    logic                  r_ready_q;
    logic [PAYLOAD_W-1:0]  r_head_q;
    logic [PAYLOAD_W-1:0]  w_head_d;
    logic [PAYLOAD_W-1:0]  r_tail_q;
    logic [PAYLOAD_W-1:0]  w_tail_d;

    logic w_push;
    logic w_pop;

    assign w_push       = i_push_valid & r_ready_q;
    assign w_pop        = (r_state_q != Q_EMPTY) & i_pop_ready;
    assign o_push_ready = r_ready_q;
    assign o_pop_valid  = (r_state_q != Q_EMPTY);
    assign o_pop_data   = r_head_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= Q_EMPTY;
            r_ready_q <= 1'b1;
            r_head_q  <= '0;
            r_tail_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            // Ready for the next cycle follows the next occupancy, so it is
            // available straight from a flop.
            r_ready_q <= (w_state_d != Q_TWO);
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_head_d  = r_head_q;
        w_tail_d  = r_tail_q;
        case (r_state_q)
            Q_EMPTY: begin
                if (w_push) begin
                    w_head_d  = i_push_data;
                    w_state_d = Q_ONE;
                end
            end
            Q_ONE: begin
                if (w_push && w_pop) begin
                    // Head leaves and the new payload replaces it
                    w_head_d  = i_push_data;
                end else if (w_push) begin
                    w_tail_d  = i_push_data;
                    w_state_d = Q_TWO;
                end else if (w_pop) begin
                    w_state_d = Q_EMPTY;
                end
            end
            Q_TWO: begin
                // Ready is low here, so only a pop can happen
                if (w_pop) begin
                    w_head_d  = r_tail_q;
                    w_state_d = Q_ONE;
                end
            end
            default: begin
                w_state_d = Q_EMPTY;
            end
        endcase
    end

endmodule : rd_skid_buf
`default_nettype wire

// File: rtl/reg_read_unit.sv
`default_nettype none
// ============================================================================
//  Module      : reg_read_unit
//  Description : Register storage with an enable-style write port and a
//                valid/ready read path of fixed 1-cycle latency, decoupled
//                from consumer backpressure by a 2-entry response queue.
//                Reads of addresses >= NUM_REGS return err=1 with data 0;
//                writes to such addresses are dropped.
//  Ports       : clk               clock
//                rst               async active-high reset
//                bus (slave)       wr_en/wr_addr/wr_data,
//                                  rd_req_valid/rd_req_ready/rd_req_addr,
//                                  rd_rsp_valid/rd_rsp_ready/rd_rsp_data/
//                                  rd_rsp_err
//  Options     : REG_READ_BYPASS_EN - when defined, a write in the same cycle
//                as an accepted read of the same address forwards wr_data to
//                the response; otherwise the old register value is returned.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_read_unit
    import reg_read_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int NUM_REGS = c_NUM_REGS,
    parameter int ADDR_W   = c_ADDR_W
) (
    input  wire logic        clk,
    input  wire logic        rst,
    reg_read_unit_if.slave   bus
);

    // Zero-extended bound so the range check works at full ADDR_W even when
    // NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] c_REG_LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] r_regs_q [NUM_REGS];
    logic [DATA_W-1:0] w_regs_d [NUM_REGS];

    logic              w_wr_hit;
    logic              w_rd_err;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W:0]   w_rsp_in;
    logic [DATA_W:0]   w_rsp_out;

    assign w_wr_hit = bus.wr_en & ({1'b0, bus.wr_addr} < c_REG_LIMIT);
    assign w_rd_err = ({1'b0, bus.rd_req_addr} >= c_REG_LIMIT);

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_regs_d[i] = r_regs_q[i];
            if (w_wr_hit && (bus.wr_addr == ADDR_W'(i))) begin
                w_regs_d[i] = bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs_q[i] <= '0;
            end
        end else begin
            r_regs_q <= w_regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read sample: storage as it stands before this edge's write. An
    // out-of-range address matches no register and yields zero data.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_req_addr == ADDR_W'(i)) begin
                w_rd_data = r_regs_q[i];
            end
        end
`ifdef REG_READ_BYPASS_EN
        // A write hit is always in range, so a matching read is too
        if (w_wr_hit && (bus.wr_addr == bus.rd_req_addr)) begin
            w_rd_data = bus.wr_data;
        end
`endif
    end

    assign w_rsp_in = {w_rd_err, w_rd_data};

    // ------------------------------------------------------------------
    // Response queue
    // ------------------------------------------------------------------
    rd_skid_buf #(
        .PAYLOAD_W (DATA_W + 1)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .i_push_valid (bus.rd_req_valid),
        .o_push_ready (bus.rd_req_ready),
        .i_push_data  (w_rsp_in),
        .o_pop_valid  (bus.rd_rsp_valid),
        .i_pop_ready  (bus.rd_rsp_ready),
        .o_pop_data   (w_rsp_out)
    );

    assign bus.rd_rsp_err  = w_rsp_out[DATA_W];
    assign bus.rd_rsp_data = w_rsp_out[DATA_W-1:0];

endmodule : reg_read_unit
`default_nettype wire
